jumpstate_counter: RTL and testbench
====================================

# jumpstate_counter

Game-flow controller for the Doodle Jump core: a small Moore state machine that sequences idle, play, pause and the platform-scroll/reload steps from keyboard codes and the physics engine's scroll request, plus a free-running up-counter used for velocity ramping and scroll pacing. The block sits between the USB keyboard keycode path and the jump/physics logic. The physics logic decodes `outstate` to choose its per-frame behaviour, and the platform generator uses `loadplat`.

## Interface
- `CNT_WIDTH`, 16, width of the up-counter output.
- `Clk`  input  1  single clock for FSM and counter (frame clock in system use).
- `Reset`  input  1  asynchronous, active-high; clears all state.
- `Keycode`  input  8  current USB HID keycode; 0 = no key.
- `refresh_en`  input  1  scroll request from physics logic.
- `cnt_enable`  input  1  counter increment enable.
- `cnt_clr`  input  1  synchronous counter clear.
- `outstate`  output  3  current FSM state encoding.
- `loadplat`  output  1  one-cycle pulse to load or refresh platforms.
- `count`  output  CNT_WIDTH  counter value.

## Operation
- FSM states and encodings, all registered Moore outputs:
  - IDLE = 3'b000: waiting for start.
  - PLAY = 3'b001: normal gameplay.
  - PAUSE = 3'b010: motion frozen.
  - DISPLACE = 3'b011: scroll displacement capture.
  - LOAD = 3'b100: platform reload; `loadplat` = 1 only in this state.
- Encodings 101–111 are illegal and return to IDLE on the next clock.
- Keycodes: ENTER = 8'h28, P = 8'h13, ESC = 8'h29.
- Transitions, evaluated each rising `Clk` in listed priority:
  - Any state, `Keycode` == ESC → IDLE.
  - IDLE: ENTER → PLAY; otherwise stay.
  - PLAY: P → PAUSE; else `refresh_en` = 1 → DISPLACE; otherwise stay.
  - PAUSE: ENTER → PLAY; otherwise stay. `refresh_en` is ignored.
  - DISPLACE → LOAD unconditionally after 1 cycle.
  - LOAD → PLAY unconditionally after 1 cycle.
- If `refresh_en` is still high on return to PLAY, the DISPLACE/LOAD cycle repeats. PLAY→DISPLACE→LOAD→PLAY is therefore a 3-cycle loop.
- P and ENTER are level-sensitive. A held P while in PAUSE keeps the FSM in PAUSE. A held ENTER in PAUSE resumes PLAY.
- Counter:
  - `cnt_clr` = 1: count ← 0. Clear has priority over enable.
  - Else `cnt_enable` = 1: count ← count + 1, modulo 2^CNT_WIDTH; wraps from all-ones to 0.
  - Else: hold.
- The counter runs independently of FSM state.

## Timing
- Reset (asynchronous, any time including mid-sequence): `outstate` = 3'b000, `loadplat` = 0, `count` = 0, taking effect immediately.
- First state change occurs on the first rising `Clk` after `Reset` deasserts.
- All outputs change only on the rising `Clk` edge, with 1-cycle latency from input to output.
- `loadplat` is high for exactly one cycle per LOAD entry. It is never asserted outside LOAD.
- Simultaneous inputs in PLAY:
  - P and `refresh_en` both high → PAUSE.
  - ESC and anything else → IDLE.
- Simultaneous `cnt_clr` and `cnt_enable` → count = 0 on that edge, 1 on the next edge if enable persists.
- The counter's low bits are consumed directly downstream:
  - bit 0 and bit 1 feed the velocity ramp.
  - bit 4 paces the scroll step.
  - bit 5 feeds a second counter's enable.
- The counter must therefore be a pure binary up-count with no skipped values.

## Test plan
- Reset while in PLAY with count = 37 → outstate = 000, loadplat = 0, count = 0 immediately; stays IDLE with Keycode = 0.
- IDLE, Keycode = 8'h28 for 1 cycle → outstate = 001 after the next edge; Keycode = 8'h13 → 010; Keycode = 8'h28 → 001.
- PLAY, pulse refresh_en = 1 for one cycle → outstate sequence 011, 100, 001; loadplat = 1 only in the 100 cycle.
- PLAY with refresh_en held high 6 cycles → outstate cycles 011, 100, 001 twice; loadplat pulses twice.
- Keycode = 8'h29 in each of PLAY, PAUSE, DISPLACE → outstate = 000 next cycle.
- Counter with CNT_WIDTH = 16:
  - enable held from 0xFFFE → 0xFFFF, then 0x0000.
  - clr and enable together at 0x0010 → 0x0000.
  - enable low → count holds.

Source files
------------

// File: rtl/jumpstate_counter_if.sv
// rtl/jumpstate_counter_if.sv - keyboard/physics control bundle for the game-flow controller
interface jumpstate_counter_if #(
  parameter int CNT_WIDTH = 16
);
  logic [7:0]           Keycode;
  logic                 refresh_en;
  logic                 cnt_enable;
  logic                 cnt_clr;
  logic [2:0]           outstate;
  logic                 loadplat;
  logic [CNT_WIDTH-1:0] count;

  modport master (
    output Keycode, refresh_en, cnt_enable, cnt_clr,
    input  outstate, loadplat, count
  );

  modport slave (
    input  Keycode, refresh_en, cnt_enable, cnt_clr,
    output outstate, loadplat, count
  );
endinterface

// File: rtl/jumpstate_counter.sv
// rtl/jumpstate_counter.sv - Moore game-flow FSM (idle/play/pause/scroll) plus free-running up-counter
module jumpstate_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  jumpstate_counter_if.slave bus
);

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_P     = 8'h13;
  localparam logic [7:0] KEY_ESC   = 8'h29;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    PLAY     = 3'b001,
    PAUSE    = 3'b010,
    DISPLACE = 3'b011,
    LOAD     = 3'b100
  } state_e;

  state_e               state_q, state_d;
  logic                 loadplat_q, loadplat_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      loadplat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      loadplat_q <= loadplat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.Keycode == KEY_ESC) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (bus.Keycode == KEY_ENTER) state_d = PLAY;
        PLAY: begin
          if (bus.Keycode == KEY_P)  state_d = PAUSE;
          else if (bus.refresh_en)   state_d = DISPLACE;
        end
        PAUSE:    if (bus.Keycode == KEY_ENTER) state_d = PLAY;
        DISPLACE: state_d = LOAD;
        LOAD:     state_d = PLAY;
        default:  state_d = IDLE;
      endcase
    end
    // loadplat is registered alongside the state so it is a clean pulse for the platform generator
    loadplat_d = (state_d == LOAD);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.cnt_clr) begin
      count_d = '0;
    end else if (bus.cnt_enable) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.outstate = state_q;
  assign bus.loadplat = loadplat_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_jumpstate_counter.sv
// tb/tb_jumpstate_counter.sv - vector table plus scoreboard checks for jumpstate_counter
module tb_jumpstate_counter;

  logic Clk;
  logic Reset;

  jumpstate_counter_if #(.CNT_WIDTH(16)) bus ();

  jumpstate_counter #(.CNT_WIDTH(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  key;
    logic        rf;
    logic        en;
    logic        clr;
    logic [2:0]  exp_state;
    logic        exp_load;
    logic [15:0] exp_count;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];
  vec_t sb [$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] key, input logic rf,
                      input logic en, input logic clr, input logic [2:0] es,
                      input logic el, input logic [15:0] ec);
    vec_t v;
    vec_t got;
    bus.Keycode    = key;
    bus.refresh_en = rf;
    bus.cnt_enable = en;
    bus.cnt_clr    = clr;
    v = '{key, rf, en, clr, es, el, ec};
    sb.push_back(v);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      check({tag, ".state"}, int'(bus.outstate), int'(got.exp_state));
      check({tag, ".load"},  int'(bus.loadplat), int'(got.exp_load));
      check({tag, ".count"}, int'(bus.count),    int'(got.exp_count));
    end
  endtask

  initial begin
    //               key    rf  en  clr  state   load count
    vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0};
    vecs[1]  = '{8'h28, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 16'd0};
    vecs[2]  = '{8'h13, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 16'd0};
    vecs[3]  = '{8'h13, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 16'd0};
    vecs[4]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 16'd0};
    vecs[5]  = '{8'h28, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 16'd0};
    vecs[6]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 16'd0};
    vecs[7]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 16'd0};
    vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 16'd0};
    vecs[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 16'd0};
    vecs[10] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 16'd0};
    vecs[11] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 16'd0};
    vecs[12] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 16'd0};
    vecs[13] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 16'd0};
    vecs[14] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 16'd0};
    vecs[15] = '{8'h13, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 16'd0};
    vecs[16] = '{8'h29, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0};
    vecs[17] = '{8'h28, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 16'd0};
    vecs[18] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 16'd0};
    vecs[19] = '{8'h29, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0};
    vecs[20] = '{8'h28, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 16'd0};
    vecs[21] = '{8'h29, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0};
    vecs[22] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 16'd1};
    vecs[23] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 16'd2};
    vecs[24] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 16'd2};
    vecs[25] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 16'd0};
    vecs[26] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 16'd1};
    vecs[27] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 16'd0};

    Reset          = 1'b1;
    bus.Keycode    = 8'h00;
    bus.refresh_en = 1'b0;
    bus.cnt_enable = 1'b0;
    bus.cnt_clr    = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset.state", int'(bus.outstate), 0);
    check("reset.load",  int'(bus.loadplat), 0);
    check("reset.count", int'(bus.count),    0);
    Reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("vec%0d", i), vecs[i].key, vecs[i].rf, vecs[i].en, vecs[i].clr,
           vecs[i].exp_state, vecs[i].exp_load, vecs[i].exp_count);
    end

    // Count all the way up to the wrap point
    for (int i = 1; i <= 16'hFFFE; i++) begin
      step("ramp", 8'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 16'(i));
    end
    step("wrap_ffff", 8'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 16'hFFFF);
    step("wrap_0000", 8'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 16'h0000);

    for (int i = 1; i <= 16; i++) begin
      step("to_0x10", 8'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 16'(i));
    end
    step("clr_en_0x10", 8'h00, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 16'h0000);
    step("after_clr",   8'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 16'h0001);
    step("hold",        8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 16'h0001);

    // Async reset in PLAY with count = 37
    step("mr_enter", 8'h28, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 16'd0);
    for (int i = 1; i <= 37; i++) begin
      step("mr_cnt", 8'h00, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 16'(i));
    end
    bus.cnt_enable = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset.state", int'(bus.outstate), 0);
    check("async_reset.load",  int'(bus.loadplat), 0);
    check("async_reset.count", int'(bus.count),    0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    step("post_reset0", 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0);
    step("post_reset1", 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
